// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and default parameters for the input debouncer
package debounce_pkg;
  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_t;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;
endpackage

// File: rtl/input_debouncer_sync_chain.sv
// sync_chain: multi-flop synchronizer bringing an asynchronous bit into the clk domain
module sync_chain #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic q_sync
);
  logic [SYNC_STAGES-1:0] sync;
  always_ff @(posedge clk)
    if (!rst) sync <= '0;
    else sync <= {sync[SYNC_STAGES-2:0], d_async};
  assign q_sync = sync[SYNC_STAGES-1];
endmodule

// File: rtl/input_debouncer.sv
// input_debouncer: synchronizes and debounces a bouncy input into a clean level plus edge pulses
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout,
  output logic rise,
  output logic fall,
  output logic busy
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  logic s;
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic dout_n, rise_n, fall_n;
  sync_chain #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk(clk),
    .rst(rst),
    .d_async(din),
    .q_sync(s)
  );
  always_ff @(posedge clk)
    if (!rst) begin
      state <= STABLE_LOW;
      cnt <= '0;
      dout <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      dout <= dout_n;
      rise <= rise_n;
      fall <= fall_n;
    end
  always_comb begin
    state_n = state;
    cnt_n = '0;
    dout_n = dout;
    rise_n = 1'b0;
    fall_n = 1'b0;
    case (state)
      STABLE_LOW: begin
        state_n = s ? WAIT_HIGH : STABLE_LOW;
        cnt_n = s ? ONE : '0;
      end
      WAIT_HIGH: begin
        state_n = !s ? STABLE_LOW : (cnt == LAST) ? STABLE_HIGH : WAIT_HIGH;
        cnt_n = (s && cnt != LAST) ? cnt + ONE : '0;
        dout_n = s && cnt == LAST;
        rise_n = s && cnt == LAST;
      end
      STABLE_HIGH: begin
        state_n = !s ? WAIT_LOW : STABLE_HIGH;
        cnt_n = !s ? ONE : '0;
      end
      WAIT_LOW: begin
        state_n = s ? STABLE_HIGH : (cnt == LAST) ? STABLE_LOW : WAIT_LOW;
        cnt_n = (!s && cnt != LAST) ? cnt + ONE : '0;
        dout_n = !(!s && cnt == LAST);
        fall_n = !s && cnt == LAST;
      end
      default: begin
        state_n = STABLE_LOW;
        dout_n = 1'b0;
      end
    endcase
  end
  assign busy = (state == WAIT_HIGH) || (state == WAIT_LOW);
endmodule
